hash_bits_off_reduce: RTL and testbench

- Downstream of the stage-3 popcount LUTs in the hash-bits-off datapath.
- Consumes NUM_COUNTS partial counts, each 5 bits wide (0..16, one per 16 hash bits). Reduces them through a registered adder tree to the total Hamming distance between the Skein hash and the target.
- Tracks the best (lowest) distance seen, plus the candidate tag that produced it, for the readback/reporting logic.

---
 rtl/hash_bits_off_pkg.sv | 11 +
 rtl/hash_bits_off_adder_level.sv | 26 ++
 rtl/hash_bits_off_reduce.sv | 113 +++++++++++
 tb/tb_hash_bits_off_reduce.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_bits_off_pkg.sv
// Shared constants for the hash-bits-off reduce stage: partial-count width,
// sum width derivation and the default / maximum score values.
package hash_bits_off_pkg;
  localparam int COUNT_W        = 5;
  localparam int DEF_NUM_COUNTS = 64;
  localparam int MAX_SCORE      = 1024;

  function automatic int sum_w(input int num_counts);
    return COUNT_W + $clog2(num_counts);
  endfunction
endpackage

// File: rtl/hash_bits_off_adder_level.sv
// One registered level of the popcount adder tree: adds adjacent pairs of
// IN_W-bit operands into (IN_W+1)-bit results.
module hash_bits_off_adder_level #(
  parameter int N_IN = 2,
  parameter int IN_W = 5
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_IN*IN_W-1:0]            in_i,
  output logic [(N_IN/2)*(IN_W+1)-1:0]    out_o
);
  logic [N_IN/2-1:0][IN_W:0] sum_d, sum_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_IN/2; i++)
      sum_d[i] = {1'b0, in_i[(2*i)*IN_W +: IN_W]} + {1'b0, in_i[(2*i+1)*IN_W +: IN_W]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign out_o = sum_q;
endmodule

// File: rtl/hash_bits_off_reduce.sv
// Adder tree over NUM_COUNTS partial popcounts plus best-score tracker.
// Optional HASH_BITS_OFF_THRESHOLD_EN adds threshold_i / hit_o.
module hash_bits_off_reduce
  import hash_bits_off_pkg::*;
#(
  parameter int NUM_COUNTS = DEF_NUM_COUNTS,
  parameter int TAG_W      = 64,
  localparam int SUM_W     = sum_w(NUM_COUNTS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic [NUM_COUNTS*COUNT_W-1:0] counts_i,
  input  logic [TAG_W-1:0]              tag_i,
  input  logic                          clear_i,
`ifdef HASH_BITS_OFF_THRESHOLD_EN
  input  logic [SUM_W-1:0]              threshold_i,
  output logic                          hit_o,
`endif
  output logic                          sum_valid_o,
  output logic [SUM_W-1:0]              sum_o,
  output logic [TAG_W-1:0]              sum_tag_o,
  output logic                          best_valid_o,
  output logic [SUM_W-1:0]              best_score_o,
  output logic [TAG_W-1:0]              best_tag_o,
  output logic                          new_best_o
);
  localparam int L = $clog2(NUM_COUNTS);

  for (genvar n = 0; n < L; n++) begin : g_lvl
    localparam int N_IN = NUM_COUNTS >> n;
    localparam int IN_W = COUNT_W + n;
    logic [(N_IN/2)*(IN_W+1)-1:0] lvl_out;
    if (n == 0) begin : g_first
      hash_bits_off_adder_level #(.N_IN(N_IN), .IN_W(IN_W)) u_lvl (
        .clk_i(clk_i), .rst_i(rst_i), .in_i(counts_i), .out_o(lvl_out));
    end else begin : g_next
      hash_bits_off_adder_level #(.N_IN(N_IN), .IN_W(IN_W)) u_lvl (
        .clk_i(clk_i), .rst_i(rst_i), .in_i(g_lvl[n-1].lvl_out), .out_o(lvl_out));
    end
  end

  assign sum_o = g_lvl[L-1].lvl_out;

  // Tag and valid ride alongside the tree, one stage per level.
  logic [L:0]              vld_pipe;
  logic [L:0][TAG_W-1:0]   tag_pipe;
  logic [L-1:0]            vld_q;
  logic [L-1:0][TAG_W-1:0] tag_q;

  assign vld_pipe[0]   = valid_i;
  assign tag_pipe[0]   = tag_i;
  assign vld_pipe[L:1] = vld_q;
  assign tag_pipe[L:1] = tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_pipe[L-1:0];
      tag_q <= tag_pipe[L-1:0];
    end
  end

  assign sum_valid_o = vld_pipe[L];
  assign sum_tag_o   = tag_pipe[L];

  typedef struct packed {
    logic             vld;
    logic [SUM_W-1:0] score;
    logic [TAG_W-1:0] tag;
  } best_t;

  best_t best_d, best_q;
  logic  new_best_d, new_best_q;

  // Clear is applied first so a coincident result loads into the empty tracker.
  always_comb begin
    best_d     = best_q;
    new_best_d = 1'b0;
    if (clear_i) best_d = '{vld: 1'b0, score: '1, tag: '0};
    if (sum_valid_o && (!best_d.vld || sum_o < best_d.score)) begin
      best_d     = '{vld: 1'b1, score: sum_o, tag: sum_tag_o};
      new_best_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_q     <= '{vld: 1'b0, score: '1, tag: '0};
      new_best_q <= 1'b0;
    end else begin
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign best_valid_o = best_q.vld;
  assign best_score_o = best_q.score;
  assign best_tag_o   = best_q.tag;
  assign new_best_o   = new_best_q;

`ifdef HASH_BITS_OFF_THRESHOLD_EN
  logic hit_d, hit_q;
  always_comb hit_d = sum_valid_o && (sum_o <= threshold_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) hit_q <= 1'b0;
    else       hit_q <= hit_d;
  end
  assign hit_o = hit_q;
`endif
endmodule

// File: tb/tb_hash_bits_off_reduce.sv
// Self-checking bench for hash_bits_off_reduce: scheduled-result reference
// model with a sequential best tracker, randomized and directed scenarios.
module tb_hash_bits_off_reduce;
  import hash_bits_off_pkg::*;
  localparam int N   = DEF_NUM_COUNTS;
  localparam int SW  = sum_w(N);
  localparam int TW  = 64;
  localparam int LAT = $clog2(N);
  localparam int CW  = N * COUNT_W;

  logic clk = 1'b0;
  logic rst, valid, clr;
  logic [CW-1:0] counts;
  logic [TW-1:0] tag;
  logic          sum_valid, best_valid, new_best;
  logic [SW-1:0] sum, best_score;
  logic [TW-1:0] sum_tag, best_tag;
`ifdef HASH_BITS_OFF_THRESHOLD_EN
  logic [SW-1:0] thr = '0;
  logic          hit;
`endif

  always #5 clk = ~clk;

  hash_bits_off_reduce #(.NUM_COUNTS(N), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .counts_i(counts), .tag_i(tag),
    .clear_i(clr),
`ifdef HASH_BITS_OFF_THRESHOLD_EN
    .threshold_i(thr), .hit_o(hit),
`endif
    .sum_valid_o(sum_valid), .sum_o(sum), .sum_tag_o(sum_tag),
    .best_valid_o(best_valid), .best_score_o(best_score), .best_tag_o(best_tag),
    .new_best_o(new_best));

  int tests = 0, fails = 0;
  int cyc = 0;

  // Results scheduled by the cycle they must appear at the output.
  logic          ex_v[64];
  logic [SW-1:0] ex_s[64];
  logic [TW-1:0] ex_t[64];
  logic          m_bv, m_nb, m_hit;
  logic [SW-1:0] m_bs;
  logic [TW-1:0] m_bt;

  function automatic logic [CW-1:0] mk(input int score);
    logic [CW-1:0] v;
    int r, a;
    v = '0;
    r = score;
    for (int k = 0; k < N; k++) begin
      a = (r > 16) ? 16 : r;
      v[k*COUNT_W +: COUNT_W] = COUNT_W'(a);
      r -= a;
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] rnd_counts();
    logic [CW-1:0] v;
    for (int k = 0; k < N; k++) v[k*COUNT_W +: COUNT_W] = COUNT_W'($urandom_range(0, 16));
    return v;
  endfunction

  task automatic tick(input logic v, input logic [CW-1:0] c, input logic [TW-1:0] t,
                      input logic cl, input logic r);
    int s, idx, wi;
    valid = v; counts = c; tag = t; clr = cl; rst = r;
    idx = cyc % 64;
    if (r) begin
      for (int i = 0; i < 64; i++) ex_v[i] = 1'b0;
      m_bv = 1'b0; m_bs = '1; m_bt = '0; m_nb = 1'b0; m_hit = 1'b0;
    end else begin
      m_nb = 1'b0; m_hit = 1'b0;
      if (cl) begin m_bv = 1'b0; m_bs = '1; m_bt = '0; end
      if (ex_v[idx]) begin
        if (!m_bv || ex_s[idx] < m_bs) begin
          m_bv = 1'b1; m_bs = ex_s[idx]; m_bt = ex_t[idx]; m_nb = 1'b1;
        end
`ifdef HASH_BITS_OFF_THRESHOLD_EN
        m_hit = (ex_s[idx] <= thr);
`endif
      end
      ex_v[idx] = 1'b0;
      if (v) begin
        s = 0;
        for (int k = 0; k < N; k++) s += int'(c[k*COUNT_W +: COUNT_W]);
        wi = (cyc + LAT) % 64;
        ex_v[wi] = 1'b1; ex_s[wi] = SW'(s); ex_t[wi] = t;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    tests += 7;
    if (sum_valid !== 1'b0) begin fails++; $display("FAIL reset_sum_valid got %b want 0", sum_valid); end
    if (sum !== '0) begin fails++; $display("FAIL reset_sum got %0d want 0", sum); end
    if (sum_tag !== '0) begin fails++; $display("FAIL reset_sum_tag got %h want 0", sum_tag); end
    if (best_valid !== 1'b0) begin fails++; $display("FAIL reset_best_valid got %b want 0", best_valid); end
    if (best_score !== SW'(2047)) begin fails++; $display("FAIL reset_best_score got %0d want 2047", best_score); end
    if (best_tag !== '0) begin fails++; $display("FAIL reset_best_tag got %h want 0", best_tag); end
    if (new_best !== 1'b0) begin fails++; $display("FAIL reset_new_best got %b want 0", new_best); end
    tick(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    int seen_at, pulses;
    seen_at = -1; pulses = 0;
    tick(1'b1, '0, 64'h1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (sum_valid === 1'b1 && seen_at < 0) seen_at = i;
      if (new_best === 1'b1) pulses++;
      idle(1);
    end
    tests += 5;
    if (seen_at != LAT) begin fails++; $display("FAIL single_latency got %0d want %0d", seen_at, LAT); end
    if (pulses != 1) begin fails++; $display("FAIL single_new_best_pulses got %0d want 1", pulses); end
    if (best_valid !== 1'b1) begin fails++; $display("FAIL single_best_valid got %b want 1", best_valid); end
    if (best_score !== '0) begin fails++; $display("FAIL single_best_score got %0d want 0", best_score); end
    if (best_tag !== 64'h1) begin fails++; $display("FAIL single_best_tag got %h want 1", best_tag); end
  endtask

  task automatic test_patterns();
    logic [CW-1:0] c;
    int got16, gotmod, nvalid, nseen, expmod;
    got16 = -1; gotmod = -1; nvalid = 0; nseen = 0; expmod = 0;
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) begin
      c[k*COUNT_W +: COUNT_W] = COUNT_W'(k % 17);
      expmod += k % 17;
    end
    tick(1'b1, mk(MAX_SCORE), 64'hA16, 1'b0, 1'b0);
    tick(1'b1, c, 64'hB17, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i < 8) tick(1'b1, rnd_counts(), TW'($urandom), 1'b0, 1'b0);
      else idle(1);
      if (sum_valid === 1'b1 && sum_tag === 64'hA16) got16 = int'(sum);
      if (sum_valid === 1'b1 && sum_tag === 64'hB17) gotmod = int'(sum);
      if (sum_valid !== ex_v[cyc % 64]) begin
        fails++; $display("FAIL pat_valid cyc %0d got %b want %b", cyc, sum_valid, ex_v[cyc % 64]);
      end else if (sum_valid === 1'b1) begin
        nvalid++;
        if (sum !== ex_s[cyc % 64] || sum_tag !== ex_t[cyc % 64]) begin
          fails++; $display("FAIL pat_sum cyc %0d got %0d/%h want %0d/%h", cyc, sum, sum_tag,
                            ex_s[cyc % 64], ex_t[cyc % 64]);
        end
      end
      nseen++;
    end
    idle(3);
    tests += nseen + 2;
    if (got16 != MAX_SCORE) begin fails++; $display("FAIL all16_sum got %0d want %0d", got16, MAX_SCORE); end
    if (gotmod != expmod) begin fails++; $display("FAIL kmod17_sum got %0d want %0d", gotmod, expmod); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    logic [TW-1:0] last_tag;
    nvalid = 0; last_tag = '0;
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 100 + LAT + 2; i++) begin
      if (i < 100) tick(1'b1, rnd_counts(), TW'(1000 + i), 1'b0, 1'b0);
      else idle(1);
      tests++;
      if (sum_valid !== ex_v[cyc % 64]) begin
        fails++; $display("FAIL b2b_valid cyc %0d got %b want %b", cyc, sum_valid, ex_v[cyc % 64]);
      end else if (sum_valid === 1'b1) begin
        if (nvalid > 0 && sum_tag != last_tag + 1) begin
          fails++; $display("FAIL b2b_order got %0d after %0d", sum_tag, last_tag);
        end
        last_tag = sum_tag;
        nvalid++;
        if (sum !== ex_s[cyc % 64] || sum_tag !== ex_t[cyc % 64]) begin
          fails++; $display("FAIL b2b_sum cyc %0d got %0d/%0d want %0d/%0d", cyc, sum, sum_tag,
                            ex_s[cyc % 64], ex_t[cyc % 64]);
        end
      end
      if (new_best !== m_nb || best_score !== m_bs || best_tag !== m_bt) begin
        fails++; $display("FAIL b2b_best cyc %0d got %b/%0d/%0d want %b/%0d/%0d", cyc, new_best,
                          best_score, best_tag, m_nb, m_bs, m_bt);
      end
    end
    tests++;
    if (nvalid != 100) begin fails++; $display("FAIL b2b_count got %0d want 100", nvalid); end
  endtask

  task automatic test_best_seq();
    int scores[5] = '{500, 480, 480, 490, 300};
    int pulses;
    logic [TW-1:0] pulse_tags[$];
    pulses = 0;
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5 + LAT + 2; i++) begin
      if (i < 5) tick(1'b1, mk(scores[i]), TW'(64'hC0 + i), 1'b0, 1'b0);
      else idle(1);
      if (new_best === 1'b1) begin pulses++; pulse_tags.push_back(best_tag); end
      tests++;
      if (new_best !== m_nb || best_score !== m_bs || best_tag !== m_bt) begin
        fails++; $display("FAIL seq_best cyc %0d got %b/%0d/%h want %b/%0d/%h", cyc, new_best,
                          best_score, best_tag, m_nb, m_bs, m_bt);
      end
    end
    tests += 3;
    if (pulses != 3) begin fails++; $display("FAIL seq_pulses got %0d want 3", pulses); end
    else if (pulse_tags[1] !== 64'hC1) begin
      fails++; $display("FAIL seq_tie_tag got %h want c1", pulse_tags[1]);
    end
    if (best_tag !== 64'hC4) begin fails++; $display("FAIL seq_final_tag got %h want c4", best_tag); end
    if (best_score !== SW'(300)) begin fails++; $display("FAIL seq_final_score got %0d want 300", best_score); end
  endtask

  task automatic test_clear();
    tick(1'b1, mk(100), 64'hD0, 1'b0, 1'b0);
    idle(LAT + 2);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    tests += 3;
    if (best_valid !== 1'b0) begin fails++; $display("FAIL clear_best_valid got %b want 0", best_valid); end
    if (best_score !== SW'(2047)) begin fails++; $display("FAIL clear_best_score got %0d want 2047", best_score); end
    if (best_tag !== '0) begin fails++; $display("FAIL clear_best_tag got %h want 0", best_tag); end
    tick(1'b1, mk(60), 64'hD1, 1'b0, 1'b0);
    idle(2);
    tick(1'b1, mk(700), 64'hD7, 1'b0, 1'b0);
    idle(LAT - 1);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    tests += 4;
    if (new_best !== 1'b1) begin fails++; $display("FAIL clrload_new_best got %b want 1", new_best); end
    if (best_valid !== 1'b1) begin fails++; $display("FAIL clrload_valid got %b want 1", best_valid); end
    if (best_score !== SW'(700)) begin fails++; $display("FAIL clrload_score got %0d want 700", best_score); end
    if (best_tag !== 64'hD7) begin fails++; $display("FAIL clrload_tag got %h want d7", best_tag); end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    int stray;
    stray = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, rnd_counts(), TW'(64'hE0 + i), 1'b0, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < LAT + 4; i++) begin
      if (sum_valid !== 1'b0 || new_best !== 1'b0) stray++;
      idle(1);
    end
    tests += 5;
    if (stray != 0) begin fails++; $display("FAIL midrst_stray got %0d want 0", stray); end
    if (best_valid !== 1'b0) begin fails++; $display("FAIL midrst_best_valid got %b want 0", best_valid); end
    if (best_score !== SW'(2047)) begin fails++; $display("FAIL midrst_best_score got %0d want 2047", best_score); end
    if (best_tag !== '0) begin fails++; $display("FAIL midrst_best_tag got %h want 0", best_tag); end
    if (sum !== '0 || sum_tag !== '0) begin fails++; $display("FAIL midrst_sum got %0d/%h want 0/0", sum, sum_tag); end
  endtask

`ifdef HASH_BITS_OFF_THRESHOLD_EN
  task automatic test_threshold();
    int sc[3] = '{399, 400, 401};
    logic [2:0] hits;
    int nh;
    hits = '0; nh = 0;
    thr = SW'(400);
    for (int i = 0; i < 3 + LAT + 2; i++) begin
      if (i < 3) tick(1'b1, mk(sc[i]), TW'(64'hF0 + i), 1'b0, 1'b0);
      else idle(1);
      tests++;
      if (hit !== m_hit) begin fails++; $display("FAIL thr_hit cyc %0d got %b want %b", cyc, hit, m_hit); end
      if (i == LAT + 1 || i == LAT + 2 || i == LAT + 3) begin
        hits[2 - nh] = hit; nh++;
      end
    end
    tests++;
    if (hits !== 3'b110) begin fails++; $display("FAIL thr_seq got %b want 110", hits); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) begin ex_v[i] = 1'b0; ex_s[i] = '0; ex_t[i] = '0; end
    m_bv = 1'b0; m_bs = '1; m_bt = '0; m_nb = 1'b0; m_hit = 1'b0;
    rst = 1'b1; valid = 1'b0; clr = 1'b0; counts = '0; tag = '0;
    test_reset();
    test_single();
    test_patterns();
    test_back_to_back();
    test_best_seq();
    test_clear();
    test_reset_midflight();
`ifdef HASH_BITS_OFF_THRESHOLD_EN
    test_threshold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
